aes_cipher_iter: RTL and testbench

Iterative AES-128 encryption core; forward counterpart of the team's inverse-cipher round logic.
- Takes one 128-bit plaintext block and the pre-expanded 11-round-key schedule.
- Runs the initial AddRoundKey plus 10 rounds, one round per clock.
- Presents the ciphertext with a valid/ready handshake.
- Sits beside the key-expansion block and shares its `words` bus format with the decipher path.

---
 rtl/aes_cipher_iter.sv | 150 +++++++++++++++
 tb/tb_aes_cipher_iter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 encryptor: initial AddRoundKey then one round per clock.
// Optional AES_CIPHER_KEY_LATCH_EN latches the key schedule on accept.
`timescale 1ns/1ps
module aes_cipher_iter #(
  parameter int NR = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [0:127]  in,
  input  logic [0:1407] words,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [0:127]  out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  if (NR != 10) begin : g_bad_nr
    $error("aes_cipher_iter supports only NR=10");
  end

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:127] sub_bytes(input logic [0:127] s);
    logic [0:127] o;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = SBOX[{s[8*i +: 8], 3'b000} +: 8];
    return o;
  endfunction

  // byte i sits at row i%4, column i/4; row r rotates left by r
  function automatic logic [0:127] shift_rows(input logic [0:127] s);
    logic [0:127] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
    return o;
  endfunction

  function automatic logic [0:127] mix_columns(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c      +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[32*c + 8  +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[32*c + 16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[32*c + 24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  state_t        r_state, w_next;
  logic [0:127]  r_st, r_out;
  logic [3:0]    r_rnd;
  logic [0:1407] w_key;
  logic [0:127]  w_rk, w_sr, w_round;
  logic          w_last, w_accept;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_rnd == 4'(NR));

`ifdef AES_CIPHER_KEY_LATCH_EN
  logic [0:1407] r_key;

  always_ff @(posedge clk) begin
    if (!rst_n)        r_key <= '0;
    else if (w_accept) r_key <= words;
  end

  assign w_key = r_key;
`else
  assign w_key = words;
`endif

  always_comb begin
    w_rk = '0;
    for (int r = 0; r <= 10; r++)
      if (r_rnd == 4'(r)) w_rk = w_key[128*r +: 128];
  end

  assign w_sr    = shift_rows(sub_bytes(r_st));
  assign w_round = (w_last ? w_sr : mix_columns(w_sr)) ^ w_rk;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_ROUND;
      S_ROUND: if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    busy      = (r_state == S_ROUND);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st  <= '0;
      r_rnd <= '0;
      r_out <= '0;
    end else if (w_accept) begin
      r_st  <= in ^ words[0:127];
      r_rnd <= 4'd1;
    end else if (r_state == S_ROUND) begin
      r_st  <= w_round;
      r_rnd <= r_rnd + 4'd1;
      if (w_last) r_out <= w_round;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter using FIPS-197 vectors.
// Key schedule built by an independent model (S-box derived from GF inverse).
`timescale 1ns/1ps
module tb_aes_cipher_iter;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [0:127]  tb_in;
  logic [0:1407] tb_words;
  logic          in_valid;
  logic          in_ready;
  logic [0:127]  tb_out;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_cipher_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (tb_in),
    .words     (tb_words),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (tb_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (gm(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3)
               ^ rol8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [0:1407] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [0:1407] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      res[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  logic [0:1407] kB, kC;
  int lat;

  initial begin
    kB = expand(KEY_B);
    kC = expand(KEY_C);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tb_in = '0; tb_words = kB;
    step(); step();
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_out", tb_out, 128'd0);
    rst_n = 1'b1;

    // App. B with latency measurement
    tb_in = PT_B; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("B_busy", 128'(busy), 128'd1);
    check("B_in_ready", 128'(in_ready), 128'd0);
    wait_done(lat);
    check("B_latency", 128'(lat), 128'd10);
    check("B_ct", tb_out, CT_B);

    // backpressure: new offer must be ignored while DONE
    tb_in = PT_C; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_out", tb_out, CT_B);
      check("bp_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("bp_release_in_ready", 128'(in_ready), 128'd1);
    check("bp_release_out_valid", 128'(out_valid), 128'd0);
    check("bp_out_hold", tb_out, CT_B);

    // reset at round 5
    tb_in = PT_B; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check("mid_rst_out", tb_out, 128'd0);
    check("mid_rst_in_ready", 128'(in_ready), 128'd1);
    check("mid_rst_busy", 128'(busy), 128'd0);
    tb_in = PT_B; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_done(lat);
    check("post_rst_latency", 128'(lat), 128'd10);
    check("post_rst_ct", tb_out, CT_B);
    step();

    // back-to-back: C offered throughout B's rounds and taken on return
    tb_in = PT_B; in_valid = 1'b1;
    step();
    tb_in = PT_C;
    wait_done(lat);
    check("b2b_B_latency", 128'(lat), 128'd10);
    check("b2b_B_ct", tb_out, CT_B);
    tb_words = kC;
    step();
    check("b2b_idle_in_ready", 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
    check("b2b_C_busy", 128'(busy), 128'd1);
    wait_done(lat);
    check("b2b_C_latency", 128'(lat), 128'd10);
    check("b2b_C_ct", tb_out, CT_C);
    step();

    // key scramble one cycle after accept
    tb_words = kB; tb_in = PT_B; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    tb_words = '1;
    wait_done(lat);
    check("scr_latency", 128'(lat + 1), 128'd10);
`ifdef AES_CIPHER_KEY_LATCH_EN
    check("scr_ct", tb_out, CT_B);
`endif
    tb_words = kB;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
